rice_word_decoder: RTL and testbench
====================================

# rice_word_decoder

Bit-serial Rice (Golomb power-of-two) decoder that sits directly downstream of the telemetry dual-clock FIFO, in the FIFO read-clock domain. It pulls 32-bit compressed words from the FIFO read port, unpacks them MSB-first into a continuous bitstream, and decodes each codeword into a sample. Decoded samples go to the reconstruction stage over a valid/ready handshake.

## Interface
- DATA_W, 32, FIFO word width; bitstream is consumed MSB-first, word after word.
- OUT_W, 16, decoded sample width.
- QMAX, 31, largest legal unary quotient; exceeding it is a stream error.
- rd_clk  in  1  decoder clock; same clock as the FIFO read side.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  decode enable; sampled only in IDLE.
- k  in  4  Rice parameter (0..15); sampled when a codeword starts.
- fifo_dout  in  DATA_W  FIFO read data; valid on the edge after the FIFO samples fifo_rd_en.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO read strobe, registered, one-cycle pulse per word.
- sample  out  OUT_W  decoded value.
- sample_valid  out  1  sample holds a decoded value.
- sample_ready  in  1  downstream accepts sample.
- q_err  out  1  sticky quotient-overflow flag.
- busy  out  1  high in any state other than IDLE.

## Operation
- Codeword format: q zeros, then a terminating '1', then k remainder bits MSB-first. Value = (q << k) | r, computed in OUT_W bits; bits above OUT_W are discarded.
- Word buffer:
  - DATA_W shift register plus a 6-bit bit counter and buf_valid flag.
  - One bit is consumed per cycle when the FSM is in UNARY or REM and buf_valid=1.
  - buf_valid clears on consuming bit DATA_W-1.
- Fetch logic runs independently of the FSM:
  - If buf_valid=0, no read is pending, fifo_empty=0, en=1 and not HALT: register fifo_rd_en=1 for one cycle.
  - Capture fifo_dout two edges after fifo_rd_en is set, then set buf_valid.
  - At most one read is outstanding. No prefetch beyond one buffered word.
- FSM states:
  - IDLE: go to UNARY if en=1. Latch k and clear q.
  - UNARY, per consumed bit:
    - On '0': q++.
    - On '1' with k=0: go to OUT.
    - On '1' with k>0: go to REM.
    - If q would become QMAX+1: set q_err and go to HALT.
  - REM: shift k bits into r, then go to OUT.
  - OUT: register sample and assert sample_valid. On the edge where sample_valid and sample_ready are both high, go to IDLE. If en=1, enter UNARY on the following cycle.
  - HALT: sample_valid=0, fifo_rd_en=0, no bits consumed. Leave only by reset.
- Stalls:
  - With buf_valid=0, UNARY/REM hold state and q/r without consuming bits.
  - A codeword may span any number of words.
- en deasserted mid-codeword: the codeword completes. en is checked again in IDLE.

## Timing
- Reset values (asynchronous): fifo_rd_en=0, sample=0, sample_valid=0, q_err=0, busy=0, buf_valid=0, FSM=IDLE.
- A partial word and partial codeword are discarded on reset. Reset during a pending FIFO read drops the returning word.
- Word fetch:
  - Edge E0: fifo_rd_en=1.
  - Edge E1: FIFO updates dout.
  - Edge E2: word captured.
  - Edge E3: first bit consumed.
- Codeword decode takes q+1+k bit-cycles plus stall cycles. sample_valid rises on the edge after the last bit is consumed.
- Throughput: one sample every q+1+k+2 cycles at best (OUT plus IDLE).
- Backpressure: while sample_valid=1 and sample_ready=0, sample stays stable and no bits are consumed. A pending fetch may still complete.
- q_err rises on the edge that consumes the (QMAX+1)-th consecutive zero. It stays high until rst_n.

## Test plan
- k=2, one word 32'h4B00_0000, then FIFO empty -> samples 4, 1, 0. busy stays 1 with 22 zeros counted and no further sample.
- Continue with word 32'h8000_0000 -> sample 88 (q=22 spans words, r=0). Exactly one fifo_rd_en pulse per word.
- k=0, word 32'hAAAA_AAAA -> sample 0, then fifteen samples of 1. The final '0' is held pending.
- Backpressure: hold sample_ready=0 for 5 cycles on a valid sample -> sample and sample_valid stable. Next sample is correct and no bits are lost.
- Two words 32'h0000_0000, QMAX=31 -> q_err=1 at the 32nd zero. HALT, sample_valid=0, no further fifo_rd_en.
- Assert rst_n=0 mid-REM -> all outputs return to reset values immediately. After release, a fresh word decodes from bit 31.

Source files
------------

// File: rtl/rice_word_decoder.sv
// Bit-serial Rice decoder: unpacks 32-bit FIFO words MSB-first and decodes
// (q zeros, '1', k remainder bits) codewords into OUT_W-bit samples.
module rice_word_decoder #(
    parameter int DATA_W = 32,
    parameter int OUT_W  = 16,
    parameter int QMAX   = 31
) (
    input  logic              rd_clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [3:0]        k,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic [OUT_W-1:0]  sample,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              q_err,
    output logic              busy
);
    localparam int Q_W = $clog2(QMAX + 1);
    localparam int C_W = 6;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_UNARY = 3'd1;
    localparam logic [2:0] S_REM   = 3'd2;
    localparam logic [2:0] S_OUT   = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    logic [2:0]        state;
    logic [DATA_W-1:0] sreg;
    logic [C_W-1:0]    bcnt;
    logic              buf_valid;
    logic              cap_pend;
    logic [3:0]        k_lat;
    logic [3:0]        rcnt;
    logic [Q_W-1:0]    q;
    logic [13:0]       r;

    logic              cur_bit;
    logic              consume;
    logic              fetch_go;
    logic [14:0]       r_next;
    logic [OUT_W-1:0]  q_ext;

    always_comb begin
        cur_bit  = sreg[DATA_W-1];
        consume  = buf_valid && ((state == S_UNARY) || (state == S_REM));
        fetch_go = !buf_valid && !fifo_rd_en && !cap_pend && !fifo_empty
                   && en && (state != S_HALT);
        r_next   = {r, cur_bit};
        q_ext    = OUT_W'(q);
    end

    assign busy = (state != S_IDLE);

    // fifo_dout is valid one edge after the FIFO samples fifo_rd_en, so the
    // capture happens on the edge after cap_pend is set.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_rd_en <= 1'b0;
            cap_pend   <= 1'b0;
            buf_valid  <= 1'b0;
            sreg       <= '0;
            bcnt       <= '0;
        end else begin
            fifo_rd_en <= fetch_go;
            cap_pend   <= fifo_rd_en;
            if (cap_pend) begin
                sreg      <= fifo_dout;
                bcnt      <= '0;
                buf_valid <= 1'b1;
            end else if (consume) begin
                sreg <= {sreg[DATA_W-2:0], 1'b0};
                bcnt <= bcnt + 1'b1;
                if (bcnt == C_W'(DATA_W - 1)) begin
                    buf_valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            k_lat        <= '0;
            rcnt         <= '0;
            q            <= '0;
            r            <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            q_err        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en) begin
                        state <= S_UNARY;
                        k_lat <= k;
                        q     <= '0;
                        r     <= '0;
                    end
                end
                S_UNARY: begin
                    if (consume) begin
                        if (!cur_bit) begin
                            if (q == Q_W'(QMAX)) begin
                                q_err <= 1'b1;
                                state <= S_HALT;
                            end else begin
                                q <= q + 1'b1;
                            end
                        end else if (k_lat == 4'd0) begin
                            sample       <= q_ext;
                            sample_valid <= 1'b1;
                            state        <= S_OUT;
                        end else begin
                            rcnt  <= k_lat;
                            state <= S_REM;
                        end
                    end
                end
                S_REM: begin
                    // The last remainder bit goes straight into sample; r only
                    // ever needs to hold the k-1 earlier bits.
                    if (consume) begin
                        r    <= r_next[13:0];
                        rcnt <= rcnt - 1'b1;
                        if (rcnt == 4'd1) begin
                            sample       <= (q_ext << k_lat) | OUT_W'(r_next);
                            sample_valid <= 1'b1;
                            state        <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (sample_valid && sample_ready) begin
                        sample_valid <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                S_HALT: begin
                    sample_valid <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rice_word_decoder.sv
// Self-checking bench for rice_word_decoder: FIFO model plus sample scoreboard.
module tb_rice_word_decoder;
    logic        rd_clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  k = 4'd0;
    logic [31:0] fifo_dout = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [15:0] sample;
    logic        sample_valid;
    logic        sample_ready = 1'b1;
    logic        q_err;
    logic        busy;

    int passed = 0;
    int total = 0;
    int rd_cnt = 0;
    logic [31:0] fq[$];
    logic [15:0] sb[$];

    always #5 rd_clk = ~rd_clk;

    rice_word_decoder #(.DATA_W(32), .OUT_W(16), .QMAX(31)) dut (
        .rd_clk(rd_clk), .rst_n(rst_n), .en(en), .k(k),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .sample(sample), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .q_err(q_err), .busy(busy)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge rd_clk);
        #1;
    endtask

    task automatic fifo_loop;
        forever begin
            @(posedge rd_clk);
            if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
        end
    endtask

    task automatic mon_loop;
        logic [15:0] exp;
        forever begin
            @(negedge rd_clk);
            fifo_empty = (fq.size() == 0);
            if (fifo_rd_en) rd_cnt++;
            if (rst_n && sample_valid && sample_ready) begin
                total++;
                if (sb.size() == 0) begin
                    $display("FAIL sample_unexpected got %0d expected none", sample);
                end else begin
                    exp = sb.pop_front();
                    if (sample !== exp) $display("FAIL sample got %0d expected %0d", sample, exp);
                    else passed++;
                end
            end
        end
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        fq.delete();
        sb.delete();
        tick(3);
        @(negedge rd_clk);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic wait_rd(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (fifo_rd_en) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({fifo_rd_en, sample, sample_valid, q_err, busy} !== 20'd0)
            $display("FAIL reset_outputs got %h expected 0", {fifo_rd_en, sample, sample_valid, q_err, busy});
        else passed++;
        tick(2);
        total++;
        if ({fifo_rd_en, sample_valid, busy} !== 3'b000)
            $display("FAIL reset_held got %b expected 000", {fifo_rd_en, sample_valid, busy});
        else passed++;
    endtask

    task automatic test_multi_word;
        bit ok;
        int n;
        int base;
        k = 4'd2; en = 1'b1; sample_ready = 1'b1;
        do_reset();
        base = rd_cnt;
        sb.push_back(16'd4); sb.push_back(16'd1); sb.push_back(16'd0);
        fq.push_back(32'h4B00_0000);
        wait_rd(20, ok);
        total++;
        if (!ok) $display("FAIL first_read got none expected fifo_rd_en");
        else passed++;
        n = 0;
        while (!sample_valid && n < 50) begin
            tick(1);
            n++;
        end
        total++;
        if (n != 6) $display("FAIL first_latency got %0d expected 6", n);
        else passed++;
        wait_drain(200, ok);
        total++;
        if (!ok) $display("FAIL drain_word1 got %0d pending expected 0", sb.size());
        else passed++;
        tick(40);
        total++;
        if ({busy, sample_valid} !== 2'b10)
            $display("FAIL stall_pending got busy/valid %b expected 10", {busy, sample_valid});
        else passed++;
        total++;
        if (rd_cnt - base != 1) $display("FAIL reads_word1 got %0d expected 1", rd_cnt - base);
        else passed++;
        sb.push_back(16'd88);
        fq.push_back(32'h8000_0000);
        wait_drain(200, ok);
        total++;
        if (!ok) $display("FAIL drain_span got %0d pending expected 0", sb.size());
        else passed++;
        tick(60);
        total++;
        if (rd_cnt - base != 2) $display("FAIL reads_word2 got %0d expected 2", rd_cnt - base);
        else passed++;
    endtask

    task automatic test_k0;
        bit ok;
        k = 4'd0; en = 1'b1; sample_ready = 1'b1;
        do_reset();
        sb.push_back(16'd0);
        for (int i = 0; i < 15; i++) sb.push_back(16'd1);
        fq.push_back(32'hAAAA_AAAA);
        wait_drain(300, ok);
        total++;
        if (!ok) $display("FAIL drain_k0 got %0d pending expected 0", sb.size());
        else passed++;
        tick(20);
        total++;
        if ({busy, sample_valid} !== 2'b10)
            $display("FAIL k0_tail got busy/valid %b expected 10", {busy, sample_valid});
        else passed++;
    endtask

    task automatic test_backpressure;
        bit ok;
        int n;
        k = 4'd3; en = 1'b1; sample_ready = 1'b0;
        do_reset();
        sb.push_back(16'd1); sb.push_back(16'd4); sb.push_back(16'd10);
        fq.push_back(32'h9C50_0000);
        n = 0;
        while (!sample_valid && n < 100) begin
            tick(1);
            n++;
        end
        total++;
        if (!sample_valid) $display("FAIL bp_valid got 0 expected 1");
        else passed++;
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({sample_valid, sample} !== {1'b1, 16'd1})
                $display("FAIL bp_hold cycle %0d got %b/%0d expected 1/1", i, sample_valid, sample);
            else passed++;
            tick(1);
        end
        sample_ready = 1'b1;
        wait_drain(200, ok);
        total++;
        if (!ok) $display("FAIL drain_bp got %0d pending expected 0", sb.size());
        else passed++;
    endtask

    task automatic test_q_err;
        bit ok;
        int n;
        int base;
        k = 4'd0; en = 1'b1; sample_ready = 1'b1;
        do_reset();
        base = rd_cnt;
        fq.push_back(32'h0000_0000);
        fq.push_back(32'h0000_0000);
        wait_rd(20, ok);
        total++;
        if (!ok) $display("FAIL qerr_read got none expected fifo_rd_en");
        else passed++;
        n = 0;
        while (!q_err && n < 100) begin
            tick(1);
            n++;
        end
        total++;
        if (n != 34) $display("FAIL qerr_cycle got %0d expected 34", n);
        else passed++;
        tick(50);
        total++;
        if ({q_err, busy, sample_valid, fifo_rd_en} !== 4'b1100)
            $display("FAIL halt_state got %b expected 1100", {q_err, busy, sample_valid, fifo_rd_en});
        else passed++;
        total++;
        if (rd_cnt - base != 1 || fq.size() != 1)
            $display("FAIL halt_reads got %0d reads/%0d left expected 1/1", rd_cnt - base, fq.size());
        else passed++;
    endtask

    task automatic test_reset_mid_rem;
        bit ok;
        int base;
        k = 4'd15; en = 1'b1; sample_ready = 1'b1;
        do_reset();
        fq.push_back(32'h4000_0000);
        wait_rd(20, ok);
        total++;
        if (!ok) $display("FAIL rem_read got none expected fifo_rd_en");
        else passed++;
        tick(8);
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({fifo_rd_en, sample, sample_valid, q_err, busy} !== 20'd0)
            $display("FAIL async_reset got %h expected 0", {fifo_rd_en, sample, sample_valid, q_err, busy});
        else passed++;
        k = 4'd2;
        fq.delete();
        sb.delete();
        tick(2);
        @(negedge rd_clk);
        rst_n = 1'b1;
        tick(1);
        base = rd_cnt;
        sb.push_back(16'd1);
        fq.push_back(32'hA000_0000);
        wait_drain(100, ok);
        total++;
        if (!ok) $display("FAIL fresh_word got %0d pending expected 0", sb.size());
        else passed++;
        total++;
        if (rd_cnt - base != 1) $display("FAIL fresh_reads got %0d expected 1", rd_cnt - base);
        else passed++;
    endtask

    initial begin
        fork
            fifo_loop();
            mon_loop();
        join_none
        test_reset();
        test_multi_word();
        test_k0();
        test_backpressure();
        test_q_err();
        test_reset_mid_rem();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
